// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble max scheduler: FSM encoding and default
// sizing shared with the external comparator.
package nibble_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned CMP_LAT_DEFAULT = 5;
  localparam int unsigned DEPTH_DEFAULT   = 8;
  localparam int unsigned W_DEFAULT       = 4;

  // Bits needed to hold an element count of 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nibble_max_scheduler_if.sv
// Producer / comparator / consumer signal bundle of the nibble max scheduler.
// The scheduler uses the slave view; the surrounding system uses master.
interface nibble_max_scheduler_if
  import nibble_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned W     = W_DEFAULT
);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          in_ready;
  logic [W-1:0]  cmp_a;
  logic [W-1:0]  cmp_b;
  logic [W-1:0]  cmp_result;
  logic          busy;
  logic          out_valid;
  logic [W-1:0]  out_max;
  logic [CW-1:0] out_count;
  logic          out_ready;

  modport master (
    output in_valid, in_data, in_last, cmp_result, out_ready,
    input  in_ready, cmp_a, cmp_b, busy, out_valid, out_max, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, cmp_result, out_ready,
    output in_ready, cmp_a, cmp_b, busy, out_valid, out_max, out_count
  );

endinterface

// File: rtl/nibble_burst_buffer.sv
// DEPTH x W burst register file. The write pointer doubles as the element
// count once the burst is closed; reads are indexed and combinational.
module nibble_burst_buffer
  import nibble_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned W     = W_DEFAULT
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       clr_i,
  input  logic [cnt_width(DEPTH)-1:0] rd_idx_i,
  output logic [cnt_width(DEPTH)-1:0] count_o,
  output logic [W-1:0]               rd_data_o
);
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q;
  logic [CW-1:0] wr_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
    end else if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if (wr_en_i && !clr_i) begin
        mem_q[AW'(wr_ptr_q)] <= wr_data_i;
      end
    end
  end

  assign count_o   = wr_ptr_q;
  assign rd_data_o = mem_q[AW'(rd_idx_i)];

endmodule

// File: rtl/nibble_max_scheduler.sv
// Buffers a nibble burst, then walks it through the shared external
// comparator one pair at a time (running max vs next element).
module nibble_max_scheduler
  import nibble_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEFAULT,
  parameter int unsigned W       = W_DEFAULT,
  parameter int unsigned CMP_LAT = CMP_LAT_DEFAULT
)(
  input  logic                  clk,
  input  logic                  reset,
  nibble_max_scheduler_if.slave bus
);
  localparam int unsigned CW  = cnt_width(DEPTH);
  localparam int unsigned WCW = (CMP_LAT < 1) ? 1 : $clog2(CMP_LAT + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  rd_idx_q, rd_idx_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [W-1:0]   max_q, max_d;
  logic [W-1:0]   cmp_a_q, cmp_a_d;
  logic [W-1:0]   cmp_b_q, cmp_b_d;
  logic [W-1:0]   out_max_q, out_max_d;
  logic [CW-1:0]  out_count_q, out_count_d;
  logic           out_valid_q, out_valid_d;

  logic           buf_wr_en;
  logic           buf_clr;
  logic [CW-1:0]  buf_count;
  logic [W-1:0]   buf_rd_data;

  nibble_burst_buffer #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (buf_wr_en),
    .wr_data_i (bus.in_data),
    .clr_i     (buf_clr),
    .rd_idx_i  (rd_idx_q),
    .count_o   (buf_count),
    .rd_data_o (buf_rd_data)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    rd_idx_d    = rd_idx_q;
    wait_cnt_d  = wait_cnt_q;
    max_d       = max_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    out_max_d   = out_max_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    buf_wr_en   = 1'b0;
    buf_clr     = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (bus.in_valid) begin
          buf_wr_en = 1'b1;
          if (buf_count == '0) begin
            max_d = bus.in_data;
          end
          // Burst closes on in_last or when the buffer fills.
          if (bus.in_last || (buf_count == CW'(DEPTH - 1))) begin
            if (buf_count == '0) begin
              state_d     = ST_DONE;
              out_max_d   = bus.in_data;
              out_count_d = CW'(1);
              out_valid_d = 1'b1;
            end else begin
              rd_idx_d = CW'(1);
              state_d  = ST_ISSUE;
            end
          end
        end
      end

      ST_ISSUE: begin
        cmp_a_d    = max_q;
        cmp_b_d    = buf_rd_data;
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        // Sample one edge after the comparator output has settled.
        if (wait_cnt_q == WCW'(CMP_LAT)) begin
          max_d    = bus.cmp_result;
          rd_idx_d = rd_idx_q + CW'(1);
          if (rd_idx_q == (buf_count - CW'(1))) begin
            state_d     = ST_DONE;
            out_max_d   = bus.cmp_result;
            out_count_d = buf_count;
            out_valid_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          buf_clr     = 1'b1;
          state_d     = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_LOAD;
      rd_idx_q    <= '0;
      wait_cnt_q  <= '0;
      max_q       <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      out_max_q   <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      max_q       <= max_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      out_max_q   <= out_max_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // in_ready is held low while reset is asserted, independent of state.
  assign bus.in_ready  = reset && (state_q == ST_LOAD);
  assign bus.busy      = (state_q != ST_LOAD);
  assign bus.cmp_a     = cmp_a_q;
  assign bus.cmp_b     = cmp_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_max   = out_max_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_nibble_max_scheduler.sv
// Directed bench for nibble_max_scheduler with a behavioural CMP_LAT-deep
// comparator model driving cmp_result.
module tb_nibble_max_scheduler;
  import nibble_pkg::*;

  localparam int CL = CMP_LAT_DEFAULT;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  nibble_max_scheduler_if #(.DEPTH(8), .W(4)) bus();

  nibble_max_scheduler #(.DEPTH(8), .W(4), .CMP_LAT(CL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Comparator: max(cmp_a, cmp_b) appears CL edges after the operands change.
  logic [3:0] cmp_pipe [CL];
  always @(posedge clk) begin
    cmp_pipe[0] <= (bus.cmp_a > bus.cmp_b) ? bus.cmp_a : bus.cmp_b;
    for (int i = 1; i < CL; i++) cmp_pipe[i] <= cmp_pipe[i-1];
  end
  assign bus.cmp_result = cmp_pipe[CL-1];

  task automatic send_burst(input logic [3:0] d [8], input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL send_in_ready beat %0d: got %b want 1", i, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      bus.in_last  = use_last && (i == n - 1);
    end
  endtask

  // lat = number of edges after the last accept until out_valid is seen, -1 on timeout.
  task automatic wait_valid(output int lat, output bit saw_ready, output bit all_busy);
    lat = -1; saw_ready = 1'b0; all_busy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (bus.in_ready === 1'b1) saw_ready = 1'b1;
      if (bus.busy !== 1'b1) all_busy = 1'b0;
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 4'h0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (bus.cmp_a !== 4'h0) begin failures++; $display("FAIL rst_cmp_a: got %h want 0", bus.cmp_a); end
    checks++; if (bus.cmp_b !== 4'h0) begin failures++; $display("FAIL rst_cmp_b: got %h want 0", bus.cmp_b); end
    checks++; if (bus.out_max !== 4'h0) begin failures++; $display("FAIL rst_out_max: got %h want 0", bus.out_max); end
    checks++; if (bus.out_count !== 4'd0) begin failures++; $display("FAIL rst_out_count: got %0d want 0", bus.out_count); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [3:0] d [8];
    int lat; bit sr, ab;
    d = '{4'h3, 4'h9, 4'h1, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
    bus.out_ready = 1'b1;
    send_burst(d, 4, 1'b1);
    wait_valid(lat, sr, ab);
    checks++; if (lat !== 21) begin failures++; $display("FAIL basic_latency: got %0d want 21", lat); end
    checks++; if (bus.out_max !== 4'h9) begin failures++; $display("FAIL basic_max: got %h want 9", bus.out_max); end
    checks++; if (bus.out_count !== 4'd4) begin failures++; $display("FAIL basic_count: got %0d want 4", bus.out_count); end
    checks++; if (sr !== 1'b0) begin failures++; $display("FAIL basic_ready_low: got %b want 0", sr); end
    checks++; if (ab !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b want 1", ab); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_back_to_load: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    logic [3:0] d [8];
    int lat; bit sr, ab;
    d = '{4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    bus.out_ready = 1'b1;
    send_burst(d, 1, 1'b1);
    wait_valid(lat, sr, ab);
    checks++; if (lat !== 0) begin failures++; $display("FAIL single_latency: got %0d want 0", lat); end
    checks++; if (bus.out_max !== 4'hA) begin failures++; $display("FAIL single_max: got %h want a", bus.out_max); end
    checks++; if (bus.out_count !== 4'd1) begin failures++; $display("FAIL single_count: got %0d want 1", bus.out_count); end
    checks++; if (bus.cmp_a !== 4'h9) begin failures++; $display("FAIL single_cmp_a_held: got %h want 9", bus.cmp_a); end
    checks++; if (bus.cmp_b !== 4'h7) begin failures++; $display("FAIL single_cmp_b_held: got %h want 7", bus.cmp_b); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_one_cycle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [3:0] d [8];
    int lat; bit sr, ab; bit stable;
    d = '{4'h5, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    bus.out_ready = 1'b0;
    send_burst(d, 3, 1'b1);
    wait_valid(lat, sr, ab);
    checks++; if (lat !== 14) begin failures++; $display("FAIL bp_latency: got %0d want 14", lat); end
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_max !== 4'h5 || bus.out_count !== 4'd3 || bus.in_ready !== 1'b0)
        stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL bp_hold: got %b want 1", stable); end
    // Offer an input in the handshake cycle; it must not be taken.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 4'hE; bus.in_last = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_handshake: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_after: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_full_burst();
    logic [3:0] d [8];
    int lat; bit sr, ab;
    d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    bus.out_ready = 1'b1;
    send_burst(d, 8, 1'b0);
    wait_valid(lat, sr, ab);
    checks++; if (lat !== 49) begin failures++; $display("FAIL full_latency: got %0d want 49", lat); end
    checks++; if (bus.out_max !== 4'h8) begin failures++; $display("FAIL full_max: got %h want 8", bus.out_max); end
    checks++; if (bus.out_count !== 4'd8) begin failures++; $display("FAIL full_count: got %0d want 8", bus.out_count); end
    checks++; if (sr !== 1'b0) begin failures++; $display("FAIL full_ready_low: got %b want 0", sr); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [3:0] d [8];
    int lat; bit sr, ab;
    d = '{4'h2, 4'hF, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    bus.out_ready = 1'b1;
    send_burst(d, 3, 1'b1);
    repeat (4) begin
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
    end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b want 1", bus.busy); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.cmp_a !== 4'h0) begin failures++; $display("FAIL mid_cmp_a: got %h want 0", bus.cmp_a); end
    checks++; if (bus.cmp_b !== 4'h0) begin failures++; $display("FAIL mid_cmp_b: got %h want 0", bus.cmp_b); end
    checks++; if (bus.out_max !== 4'h0) begin failures++; $display("FAIL mid_out_max: got %h want 0", bus.out_max); end
    checks++; if (bus.out_count !== 4'd0) begin failures++; $display("FAIL mid_out_count: got %0d want 0", bus.out_count); end
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL mid_ctrl: got valid=%b busy=%b ready=%b want 0 0 0", bus.out_valid, bus.busy, bus.in_ready);
    end
    reset = 1'b1;
    d = '{4'h6, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    send_burst(d, 2, 1'b1);
    wait_valid(lat, sr, ab);
    checks++; if (lat !== 7) begin failures++; $display("FAIL post_rst_latency: got %0d want 7", lat); end
    checks++; if (bus.out_max !== 4'h6) begin failures++; $display("FAIL post_rst_max: got %h want 6", bus.out_max); end
    checks++; if (bus.out_count !== 4'd2) begin failures++; $display("FAIL post_rst_count: got %0d want 2", bus.out_count); end
    @(negedge clk);
  endtask

  task automatic test_operand_hold();
    logic [3:0] d [8];
    int lat; bit held;
    d = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    bus.out_ready = 1'b1;
    send_burst(d, 2, 1'b1);
    lat = -1; held = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      if (k >= 1 && (bus.cmp_a !== 4'hF || bus.cmp_b !== 4'h0)) held = 1'b0;
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat !== 7) begin failures++; $display("FAIL hold_latency: got %0d want 7", lat); end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL hold_operands: got %b want 1", held); end
    checks++; if (bus.out_max !== 4'hF) begin failures++; $display("FAIL hold_max: got %h want f", bus.out_max); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_full_burst();
    test_reset_mid();
    test_operand_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
